// File: rtl/pkt_pkg.sv
// Shared constants, state encodings and helpers for the sensor-link packet receiver.
package pkt_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
    localparam int         NUM_CH_DEF     = 6;
    localparam int         PKT_DATA_BYTES = 2 * NUM_CH_DEF;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } byte_state_t;

    typedef enum logic [1:0] {
        P_SYNC = 2'd0,
        P_DATA = 2'd1,
        P_CHK  = 2'd2
    } pkt_state_t;

    // Bit period rounded to the nearest whole clock
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

    function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART byte receiver: 2-FF synchronizer, start-bit validation, MSB-first
// data shift and stop-bit check with recovery after a framing error.
module uart_rx
    import pkt_pkg::*;
#(
    parameter int CLK_FREQ = 18_750_000,
    parameter int BAUDRATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CPB   = clks_per_bit(CLK_FREQ, BAUDRATE);
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB);
    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic             rx_meta_r;
    logic             rx_sync_r;
    logic             rx_prev_r;
    byte_state_t      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       shreg_r;
    logic [7:0]       byte_data_r;
    logic             byte_valid_r;
    logic             frame_err_r;
    logic             busy_r;

    // Synchronizer resets low so a line held low across reset never looks like a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b0;
            rx_sync_r <= 1'b0;
            rx_prev_r <= 1'b0;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Byte FSM: times bit periods from the falling edge and samples at mid-bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= CNT_ZERO;
            bit_cnt_r    <= 3'd0;
            shreg_r      <= 8'h00;
            byte_data_r  <= 8'h00;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r <= CNT_ZERO;
                    if (rx_prev_r && !rx_sync_r) begin
                        state_r <= START;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_r == CNT_HALF) begin
                        cnt_r     <= CNT_ZERO;
                        bit_cnt_r <= 3'd0;
                        if (!rx_sync_r) begin
                            state_r <= DATA;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_r == CNT_BIT) begin
                        cnt_r     <= CNT_ZERO;
                        shreg_r   <= {shreg_r[6:0], rx_sync_r};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= STOP;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt_r == CNT_BIT) begin
                        cnt_r <= CNT_ZERO;
                        if (rx_sync_r) begin
                            byte_data_r  <= shreg_r;
                            byte_valid_r <= 1'b1;
                            state_r      <= IDLE;
                            busy_r       <= 1'b0;
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    cnt_r <= CNT_ZERO;
                    if (rx_sync_r) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign byte_data  = byte_data_r;
    assign byte_valid = byte_valid_r;
    assign frame_err  = frame_err_r;
    assign busy       = busy_r;

endmodule

// File: rtl/packet_rx.sv
// Sensor-link receive end: reassembles sync + 12 data bytes + XOR checksum
// into six 16-bit channels, with checksum, framing and inter-byte timeout checks.
module packet_rx
    import pkt_pkg::*;
#(
    parameter int         CLK_FREQ     = 18_750_000,
    parameter int         BAUDRATE     = 115200,
    parameter int         WIDTH        = 16,
    parameter int         NUM_CH       = NUM_CH_DEF,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic [NUM_CH*WIDTH-1:0]   data_out,
    output logic                      data_valid,
    output logic                      chk_err,
    output logic                      frame_err,
    output logic                      timeout
);

    localparam int NBYTES   = 2 * NUM_CH;
    localparam int IDX_W    = $clog2(NBYTES);
    localparam int TO_LIMIT = TIMEOUT_BITS * clks_per_bit(CLK_FREQ, BAUDRATE);
    localparam int TO_W     = $clog2(TO_LIMIT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_LIMIT - 1);
    localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
    localparam logic [TO_W-1:0]  TO_ZERO  = TO_W'(0);

    logic [7:0]              u_byte_data_s;
    logic                    u_byte_valid_s;
    logic                    u_frame_err_s;
    logic                    u_busy_s;

    pkt_state_t              state_r;
    logic [IDX_W-1:0]        idx_r;
    logic [7:0]              chk_r;
    logic [TO_W-1:0]         idle_cnt_r;
    logic [7:0]              buffer_r [NBYTES];
    logic [NUM_CH*WIDTH-1:0] buffer_flat_s;
    logic [NUM_CH*WIDTH-1:0] data_out_r;
    logic                    data_valid_r;
    logic                    chk_err_r;
    logic                    timeout_r;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUDRATE (BAUDRATE)
    ) u_uart_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_data  (u_byte_data_s),
        .byte_valid (u_byte_valid_s),
        .frame_err  (u_frame_err_s),
        .busy       (u_busy_s)
    );

    // Buffer is in wire order: each channel arrives high byte first
    always_comb begin
        buffer_flat_s = {(NUM_CH*WIDTH){1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            buffer_flat_s[k*WIDTH +: WIDTH] = {buffer_r[2*k], buffer_r[2*k+1]};
        end
    end

    // Packet FSM, payload buffer, running checksum and inter-byte idle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= P_SYNC;
            idx_r        <= IDX_ZERO;
            chk_r        <= 8'h00;
            idle_cnt_r   <= TO_ZERO;
            data_out_r   <= {(NUM_CH*WIDTH){1'b0}};
            data_valid_r <= 1'b0;
            chk_err_r    <= 1'b0;
            timeout_r    <= 1'b0;
            for (int i = 0; i < NBYTES; i++) begin
                buffer_r[i] <= 8'h00;
            end
        end else begin
            data_valid_r <= 1'b0;
            chk_err_r    <= 1'b0;
            timeout_r    <= 1'b0;
            if (u_frame_err_s) begin
                state_r    <= P_SYNC;
                idle_cnt_r <= TO_ZERO;
            end else if (u_byte_valid_s) begin
                idle_cnt_r <= TO_ZERO;
                case (state_r)
                    P_SYNC: begin
                        if (u_byte_data_s == SYNC_BYTE) begin
                            state_r <= P_DATA;
                            idx_r   <= IDX_ZERO;
                            chk_r   <= 8'h00;
                        end
                    end
                    P_DATA: begin
                        buffer_r[idx_r] <= u_byte_data_s;
                        chk_r           <= chk_step(chk_r, u_byte_data_s);
                        if (idx_r == IDX_LAST) begin
                            state_r <= P_CHK;
                        end else begin
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end
                    P_CHK: begin
                        if (u_byte_data_s == chk_r) begin
                            data_out_r   <= buffer_flat_s;
                            data_valid_r <= 1'b1;
                        end else begin
                            chk_err_r <= 1'b1;
                        end
                        state_r <= P_SYNC;
                    end
                    default: state_r <= P_SYNC;
                endcase
            end else if ((state_r != P_SYNC) && !u_busy_s) begin
                if (idle_cnt_r == TO_LAST) begin
                    timeout_r  <= 1'b1;
                    state_r    <= P_SYNC;
                    idle_cnt_r <= TO_ZERO;
                end else begin
                    idle_cnt_r <= idle_cnt_r + TO_ONE;
                end
            end else begin
                idle_cnt_r <= TO_ZERO;
            end
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign chk_err    = chk_err_r;
    assign frame_err  = u_frame_err_s;
    assign timeout    = timeout_r;

endmodule

// File: tb/tb_packet_rx.sv
// Directed bench for packet_rx; the clock is scaled so the link runs at 18 clk/bit
// (rounded from 17.8) which keeps whole multi-packet scenarios short.
module tb_packet_rx;

    localparam int CPB     = 18;
    localparam int TO_CLKS = 20 * CPB;
    localparam int NVEC    = 6;

    logic        clk;
    logic        rst;
    logic        rx;
    logic [95:0] data_out;
    logic        data_valid;
    logic        chk_err;
    logic        frame_err;
    logic        timeout;

    packet_rx #(
        .CLK_FREQ     (2_050_000),
        .BAUDRATE     (115200),
        .WIDTH        (16),
        .NUM_CH       (6),
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_BITS (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .chk_err    (chk_err),
        .frame_err  (frame_err),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0][7:0] seq;
        int               n;
        int               bad_idx;
        int               p100;
        int               gap;
        int               exp_dv;
        int               exp_ce;
        int               exp_fe;
        logic [95:0]      exp_out;
    } vec_t;

    vec_t vecs [NVEC];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_dv = 0, n_ce = 0, n_fe = 0, n_to = 0;
    int to_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) n_dv <= n_dv + 1;
        if (chk_err)    n_ce <= n_ce + 1;
        if (frame_err)  n_fe <= n_fe + 1;
        if (timeout) begin
            n_to   <= n_to + 1;
            to_cyc <= cyc;
        end
    end

    localparam logic [95:0] P1_WIRE = 96'h1234_5678_9ABC_DEF0_1122_3344;
    localparam logic [95:0] P1_OUT  = 96'h3344_1122_DEF0_9ABC_5678_1234;
    localparam logic [95:0] P2_WIRE = 96'hA5A5_0001_8000_FFFF_0F0F_C3C3;
    localparam logic [95:0] P2_OUT  = 96'hC3C3_0F0F_FFFF_8000_0001_A5A5;
    localparam logic [95:0] P3_WIRE = 96'h0102_0304_0506_0708_090A_0B0C;
    localparam logic [95:0] P3_OUT  = 96'h0B0C_090A_0708_0506_0304_0102;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add_byte(input int v, input logic [7:0] b);
        vecs[v].seq[vecs[v].n] = b;
        vecs[v].n++;
    endtask

    task automatic add_pkt(input int v, input logic [95:0] wire_bytes, input logic [7:0] chk);
        logic [95:0] w;
        w = wire_bytes;
        add_byte(v, 8'hA5);
        for (int i = 0; i < 12; i++) add_byte(v, w[95-8*i -: 8]);
        add_byte(v, chk);
    endtask

    // One UART frame; bit edges follow a fractional period given in hundredths of a clock
    task automatic send_byte(input logic [7:0] b, input logic stop, input int p100, input int gap);
        logic [9:0] frame;
        frame = {1'b0, b, stop};
        for (int j = 0; j < 10; j++) begin
            rx = frame[9-j];
            repeat (((j + 1) * p100) / 100 - (j * p100) / 100) @(negedge clk);
        end
        rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int b_dv, b_ce, b_fe, b_to, t_end, lat;

        for (int v = 0; v < NVEC; v++) begin
            vecs[v].seq = '0;
            vecs[v].n = 0;
            vecs[v].bad_idx = -1;
            vecs[v].p100 = 1800;
            vecs[v].gap = 0;
            vecs[v].exp_fe = 0;
        end
        add_pkt(0, P1_WIRE, 8'h45);
        vecs[0].exp_dv = 0; vecs[0].exp_ce = 1; vecs[0].exp_out = 96'h0;
        add_pkt(1, P1_WIRE, 8'h44);
        vecs[1].exp_dv = 1; vecs[1].exp_ce = 0; vecs[1].exp_out = P1_OUT;
        add_byte(2, 8'h00); add_byte(2, 8'hFF); add_byte(2, 8'h3C);
        add_pkt(2, P2_WIRE, 8'h81);
        vecs[2].gap = 3;
        vecs[2].exp_dv = 1; vecs[2].exp_ce = 0; vecs[2].exp_out = P2_OUT;
        add_byte(3, 8'hA5); add_byte(3, 8'h12); add_byte(3, 8'h34); add_byte(3, 8'h56); add_byte(3, 8'h78);
        add_pkt(3, P3_WIRE, 8'h0C);
        vecs[3].bad_idx = 4; vecs[3].gap = 40;
        vecs[3].exp_dv = 1; vecs[3].exp_ce = 0; vecs[3].exp_fe = 1; vecs[3].exp_out = P3_OUT;
        add_pkt(4, P2_WIRE, 8'h81);
        vecs[4].p100 = 1836;
        vecs[4].exp_dv = 1; vecs[4].exp_ce = 0; vecs[4].exp_out = P2_OUT;
        add_pkt(5, P1_WIRE, 8'h44);
        vecs[5].p100 = 1764;
        vecs[5].exp_dv = 1; vecs[5].exp_ce = 0; vecs[5].exp_out = P1_OUT;

        rst = 1'b1;
        rx  = 1'b1;
        idle(5);
        check("rst_data_out", data_out, 96'h0);
        check("rst_data_valid", 96'(data_valid), 96'h0);
        check("rst_chk_err", 96'(chk_err), 96'h0);
        check("rst_frame_err", 96'(frame_err), 96'h0);
        check("rst_timeout", 96'(timeout), 96'h0);
        rst = 1'b0;
        idle(20);

        for (int v = 0; v < NVEC; v++) begin
            b_dv = n_dv; b_ce = n_ce; b_fe = n_fe; b_to = n_to;
            for (int i = 0; i < vecs[v].n; i++) begin
                send_byte(vecs[v].seq[i], (i == vecs[v].bad_idx) ? 1'b0 : 1'b1,
                          vecs[v].p100, vecs[v].gap);
            end
            idle(50);
            check($sformatf("v%0d_dv", v), 96'(n_dv - b_dv), 96'(vecs[v].exp_dv));
            check($sformatf("v%0d_ce", v), 96'(n_ce - b_ce), 96'(vecs[v].exp_ce));
            check($sformatf("v%0d_fe", v), 96'(n_fe - b_fe), 96'(vecs[v].exp_fe));
            check($sformatf("v%0d_to", v), 96'(n_to - b_to), 96'h0);
            check($sformatf("v%0d_data", v), data_out, vecs[v].exp_out);
        end

        // Short low glitch on an idle line, then a long idle outside any packet
        b_dv = n_dv; b_fe = n_fe; b_to = n_to;
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(TO_CLKS + 100);
        check("glitch_dv", 96'(n_dv - b_dv), 96'h0);
        check("glitch_fe", 96'(n_fe - b_fe), 96'h0);
        check("glitch_to", 96'(n_to - b_to), 96'h0);
        check("glitch_data", data_out, P1_OUT);

        // Sync plus four bytes, then 25 idle bit-times
        b_dv = n_dv; b_to = n_to;
        send_byte(8'hA5, 1'b1, 1800, 0);
        send_byte(8'h11, 1'b1, 1800, 0);
        send_byte(8'h22, 1'b1, 1800, 0);
        send_byte(8'h33, 1'b1, 1800, 0);
        send_byte(8'h44, 1'b1, 1800, 0);
        t_end = cyc;
        idle(25 * CPB);
        check("to_count", 96'(n_to - b_to), 96'h1);
        check("to_dv", 96'(n_dv - b_dv), 96'h0);
        lat = (n_to != b_to) ? (to_cyc - t_end) : -1;
        n_cmp++;
        if (lat < TO_CLKS - 15 || lat > TO_CLKS + 5) begin
            n_bad++;
            $display("FAIL to_latency: got %0d clk after last byte, expected about %0d", lat, TO_CLKS - 5);
        end
        b_dv = n_dv;
        for (int i = 0; i < 14; i++) send_byte(vecs[3].seq[i + 5], 1'b1, 1800, 0);
        idle(50);
        check("after_to_dv", 96'(n_dv - b_dv), 96'h1);
        check("after_to_data", data_out, P3_OUT);

        // Reset asserted and released in the middle of a byte of a partial packet
        send_byte(8'hA5, 1'b1, 1800, 0);
        send_byte(8'h12, 1'b1, 1800, 0);
        send_byte(8'h34, 1'b1, 1800, 0);
        b_fe = n_fe;
        fork
            send_byte(8'h00, 1'b1, 1800, 2 * CPB);
            begin
                idle(60);
                rst = 1'b1;
                idle(3);
                check("midrst_data", data_out, 96'h0);
                check("midrst_dv", 96'(data_valid), 96'h0);
                rst = 1'b0;
            end
        join
        b_dv = n_dv;
        for (int i = 0; i < 14; i++) send_byte(vecs[1].seq[i], 1'b1, 1800, 0);
        idle(50);
        check("after_rst_fe", 96'(n_fe - b_fe), 96'h0);
        check("after_rst_dv", 96'(n_dv - b_dv), 96'h1);
        check("after_rst_data", data_out, P1_OUT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
